encode_cxa: RTL and testbench
=============================

# encode_cxa

Tank-level encoder: the sensing end of the 2-bit tank-level code (Nv1, Nv0) consumed by the tank-level display decoder. It samples three raw float switches mounted at low, mid and high heights in the tank and synchronizes and debounces each one. It validates the combined pattern and drives a registered level code, a change strobe and a fault flag to the irrigation controller and display path.

## Interface
Parameters:
- DEB_MAX, 50000: consecutive stable cycles required before a sensor change is accepted; legal range 1..2^DEB_W-1.
- DEB_W, 16: width of each debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- S_BAIXO  input  1  raw low float switch; 1 = submerged; asynchronous to clk.
- S_MEDIO  input  1  raw mid float switch; 1 = submerged; asynchronous.
- S_ALTO  input  1  raw high float switch; 1 = submerged; asynchronous.
- Nv1  output  1  level code MSB, registered.
- Nv0  output  1  level code LSB, registered.
- NV_UPD  output  1  one-cycle pulse when {Nv1,Nv0} changes value.
- ERRO  output  1  sensor-pattern fault flag, registered.

## Operation
- Each sensor passes through a two-flop synchronizer (sync1 -> sync2) and then through an independent debouncer holding a debounced bit deb and a counter cnt[DEB_W-1:0].
- Debouncer, per edge:
  - sync2 == deb: cnt <= 0.
  - Otherwise, cnt == DEB_MAX-1: deb <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Any return to deb before acceptance restarts the count. Pulses shorter than DEB_MAX cycles never reach deb.
- Pattern d = {deb_ALTO, deb_MEDIO, deb_BAIXO} is encoded as follows:
  - 000 -> 00 (below low; critical).
  - 001 -> 01 (low).
  - 011 -> 10 (mid).
  - 111 -> 11 (full).
- Any other pattern (010, 100, 101, 110) is invalid: a higher switch is wet while a lower one is dry.
- Output register, per edge:
  - Valid d: {Nv1,Nv0} <= code and ERRO <= 0. NV_UPD <= 1 only if the code differs from the current {Nv1,Nv0}, else 0.
  - Invalid d: {Nv1,Nv0} hold the last valid code, ERRO <= 1, NV_UPD <= 0.
- Recovery from invalid to valid: ERRO clears on the same edge the new code loads. NV_UPD pulses only if the recovered code differs from the held code.
- Sensors change independently. Simultaneous changes on several sensors are accepted on whatever edge each debouncer completes. Transient invalid patterns between those edges raise ERRO for exactly the cycles they persist.
- Counter never wraps: it is bounded by the DEB_MAX-1 compare.

## Timing
- Reset values (asynchronous, immediate):
  - sync flops, deb bits and cnt: 0.
  - Nv1 = 0, Nv0 = 0, NV_UPD = 0, ERRO = 0.
- Reset asserted mid-count discards all progress. After release, the sensors re-debounce from deb = 000, so a full tank reports 11 only after DEB_MAX+2 cycles.
- Latency: a raw change first captured in sync1 at edge k, and held stable, gives:
  - sync2 updated at edge k+1.
  - deb updated at edge k+1+DEB_MAX.
  - Nv1/Nv0/NV_UPD/ERRO updated at edge k+2+DEB_MAX.
- NV_UPD is high for exactly one cycle per code change. Back-to-back changes on consecutive edges give consecutive pulses.
- There is no handshake. Consumers sample Nv1/Nv0 at any time; all outputs are glitch-free registered signals.

## Test plan
All scenarios use DEB_MAX=4, DEB_W=3.
- Reset, then all sensors 0 -> Nv=00, ERRO=0 and NV_UPD=0 throughout; async rst mid-cycle forces all outputs to 0 without waiting for an edge.
- S_BAIXO 0->1 captured at edge k, held -> Nv=01 and NV_UPD=1 at edge k+6 only; NV_UPD=0 at k+7.
- S_BAIXO high, then S_MEDIO pulses high for 3 cycles -> no change to Nv/ERRO/NV_UPD; the same pulse held 4+ cycles -> Nv=10 with a single NV_UPD pulse.
- From 11 (all wet), S_MEDIO alone drops to 0 and holds -> pattern 101: Nv stays 11, ERRO=1, NV_UPD=0. S_MEDIO returns to 1 -> ERRO=0, no NV_UPD.
- From 01, S_ALTO rises (pattern 101) -> ERRO=1 with Nv held at 01. S_MEDIO then rises -> ERRO=0, Nv=11, one NV_UPD pulse.
- Fill 000->001->011->111, then drain back to 000, each step held 10 cycles -> codes 01, 10, 11, 10, 01, 00, each with exactly one NV_UPD, and ERRO never set.

Source files
------------

// File: rtl/encode_cxa.sv
// encode_cxa: tank-level encoder.
// Three float switches (low/mid/high) are synchronized, debounced and
// validated. A valid thermometer pattern becomes a registered 2-bit level
// code. The block pulses NV_UPD when the code changes. Impossible wet/dry
// combinations raise ERRO while the last good code is held.
module encode_cxa #(
  parameter int DEB_MAX = 50000,
  parameter int DEB_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic S_BAIXO,
  input  logic S_MEDIO,
  input  logic S_ALTO,
  output logic Nv1,
  output logic Nv0,
  output logic NV_UPD,
  output logic ERRO
);

  // Last count value before a sensor change is accepted; the counter never
  // goes past it, so it cannot wrap.
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_MAX - 1);
  localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0] CNT_ZERO = DEB_W'(0);

  // Bit order everywhere: [2] = high, [1] = mid, [0] = low.
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_deb;
  logic       w_valid;
  logic [1:0] w_code;
  logic [1:0] r_nv;
  logic       r_upd;
  logic       r_err;

  assign w_raw = {S_ALTO, S_MEDIO, S_BAIXO};

  // Two-flop synchronizer for the asynchronous float switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic             r_deb;
    logic [DEB_W-1:0] r_cnt;

    // Accept a new sensor value only after DEB_MAX consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_deb <= 1'b0;
        r_cnt <= CNT_ZERO;
      end else if (r_sync2[g] == r_deb) begin
        r_cnt <= CNT_ZERO;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2[g];
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end

    assign w_deb[g] = r_deb;
  end

  // Map the debounced pattern to a level code; only thermometer patterns are legal.
  always_comb begin
    w_valid = 1'b0;
    w_code  = 2'b00;
    case (w_deb)
      3'b000: begin
        w_valid = 1'b1;
        w_code  = 2'b00;
      end
      3'b001: begin
        w_valid = 1'b1;
        w_code  = 2'b01;
      end
      3'b011: begin
        w_valid = 1'b1;
        w_code  = 2'b10;
      end
      3'b111: begin
        w_valid = 1'b1;
        w_code  = 2'b11;
      end
      default: begin
        w_valid = 1'b0;
        w_code  = 2'b00;
      end
    endcase
  end

  // Register level code, change strobe and fault flag; hold the code while faulted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nv  <= 2'b00;
      r_upd <= 1'b0;
      r_err <= 1'b0;
    end else if (w_valid) begin
      r_nv  <= w_code;
      r_upd <= (w_code != r_nv);
      r_err <= 1'b0;
    end else begin
      r_nv  <= r_nv;
      r_upd <= 1'b0;
      r_err <= 1'b1;
    end
  end

  assign Nv1    = r_nv[1];
  assign Nv0    = r_nv[0];
  assign NV_UPD = r_upd;
  assign ERRO   = r_err;

endmodule

// File: tb/tb_encode_cxa.sv
// Testbench for encode_cxa with DEB_MAX=4, DEB_W=3.
// Directed scenarios plus randomized sensor patterns, all checked against a
// behavioural model built on sample history and a wet-switch count.
module tb_encode_cxa;

  localparam int DEB = 4;

  logic clk;
  logic rst;
  logic s_baixo;
  logic s_medio;
  logic s_alto;
  logic nv1;
  logic nv0;
  logic nv_upd;
  logic erro;

  int n_assert;
  int n_fail;
  int obs_upd_cnt;
  int obs_err_cnt;

  // Reference model state.
  bit       hq [3][$];
  bit [2:0] m_deb;
  logic [1:0] exp_nv;
  logic       exp_upd;
  logic       exp_err;

  encode_cxa #(.DEB_MAX(DEB), .DEB_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .S_BAIXO(s_baixo),
    .S_MEDIO(s_medio),
    .S_ALTO (s_alto),
    .Nv1    (nv1),
    .Nv0    (nv0),
    .NV_UPD (nv_upd),
    .ERRO   (erro)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] p);
    {s_alto, s_medio, s_baixo} = p;
  endtask

  task automatic model_reset();
    m_deb   = 3'b000;
    exp_nv  = 2'b00;
    exp_upd = 1'b0;
    exp_err = 1'b0;
    for (int s = 0; s < 3; s++) begin
      hq[s].delete();
      for (int j = 0; j < 6; j++) hq[s].push_back(1'b0);
    end
  endtask

  // One clock edge of the reference model.
  // Outputs follow the wet count of the debounced switches; a sensor flips
  // once the synchronized value (raw delayed two edges) has disagreed for DEB edges.
  task automatic model_edge();
    int       wet;
    bit [2:0] raw;
    bit       flip;
    int       last;
    wet = int'(m_deb[0]) + int'(m_deb[1]) + int'(m_deb[2]);
    if (m_deb == 3'((1 << wet) - 1)) begin
      exp_upd = (2'(wet) != exp_nv);
      exp_nv  = 2'(wet);
      exp_err = 1'b0;
    end else begin
      exp_upd = 1'b0;
      exp_err = 1'b1;
    end
    raw = {s_alto, s_medio, s_baixo};
    for (int s = 0; s < 3; s++) begin
      hq[s].push_back(raw[s]);
      if (hq[s].size() > 16) void'(hq[s].pop_front());
      last = hq[s].size() - 1;
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (hq[s][last - 2 - j] == m_deb[s]) flip = 1'b0;
      end
      if (flip) m_deb[s] = ~m_deb[s];
    end
  endtask

  // Advance n edges, checking every output against the model after each.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("nv",   {nv1, nv0}, exp_nv);
      chk("upd",  {1'b0, nv_upd}, {1'b0, exp_upd});
      chk("erro", {1'b0, erro}, {1'b0, exp_err});
      obs_upd_cnt += int'(nv_upd);
      obs_err_cnt += int'(erro);
    end
  endtask

  task automatic clr_cnt();
    obs_upd_cnt = 0;
    obs_err_cnt = 0;
  endtask

  initial begin
    logic [2:0] fill_pat [6];
    logic [1:0] fill_code [6];
    logic [2:0] pat;
    int         hold;
    int         wet;

    n_assert = 0;
    n_fail   = 0;
    clr_cnt();
    rst = 1'b1;
    set_in(3'b000);
    model_reset();

    // Reset state.
    #1;
    chk("rst_nv",   {nv1, nv0}, 2'b00);
    chk("rst_upd",  {1'b0, nv_upd}, 2'b00);
    chk("rst_erro", {1'b0, erro}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    step(10);
    chk("idle_upd_cnt", 2'(obs_upd_cnt), 2'd0);
    chk("idle_err_cnt", 2'(obs_err_cnt), 2'd0);

    // Low switch latency: captured at first edge k, code at k+6.
    set_in(3'b001);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i < 7) chk("lat_pre_nv", {nv1, nv0}, 2'b00);
      if (i == 7) begin
        chk("lat_nv",  {nv1, nv0}, 2'b01);
        chk("lat_upd", {1'b0, nv_upd}, 2'b01);
      end
      if (i == 8) chk("lat_upd_clear", {1'b0, nv_upd}, 2'b00);
    end
    step(4);

    // Mid switch glitch of 3 cycles is filtered out.
    clr_cnt();
    set_in(3'b011);
    step(3);
    set_in(3'b001);
    step(12);
    chk("glitch_upd_cnt", 2'(obs_upd_cnt), 2'd0);
    chk("glitch_err_cnt", 2'(obs_err_cnt), 2'd0);
    chk("glitch_nv", {nv1, nv0}, 2'b01);

    // Mid switch held long enough is accepted with a single pulse.
    clr_cnt();
    set_in(3'b011);
    step(12);
    chk("mid_upd_cnt", 2'(obs_upd_cnt), 2'd1);
    chk("mid_nv", {nv1, nv0}, 2'b10);

    // Full, then mid drops alone: fault with code held.
    set_in(3'b111);
    step(12);
    chk("full_nv", {nv1, nv0}, 2'b11);
    clr_cnt();
    set_in(3'b101);
    step(12);
    chk("f101_nv",   {nv1, nv0}, 2'b11);
    chk("f101_erro", {1'b0, erro}, 2'b01);
    chk("f101_upd_cnt", 2'(obs_upd_cnt), 2'd0);
    clr_cnt();
    set_in(3'b111);
    step(12);
    chk("rec_erro", {1'b0, erro}, 2'b00);
    chk("rec_upd_cnt", 2'(obs_upd_cnt), 2'd0);
    chk("rec_nv", {nv1, nv0}, 2'b11);

    // From low, high rises first (fault), then mid completes the pattern.
    set_in(3'b001);
    step(12);
    chk("back_low_nv", {nv1, nv0}, 2'b01);
    clr_cnt();
    set_in(3'b101);
    step(12);
    chk("lo_f_nv",   {nv1, nv0}, 2'b01);
    chk("lo_f_erro", {1'b0, erro}, 2'b01);
    clr_cnt();
    set_in(3'b111);
    step(12);
    chk("lo_rec_erro", {1'b0, erro}, 2'b00);
    chk("lo_rec_nv",   {nv1, nv0}, 2'b11);
    chk("lo_rec_upd_cnt", 2'(obs_upd_cnt), 2'd1);

    // Fill and drain one switch at a time.
    set_in(3'b000);
    step(12);
    fill_pat  = '{3'b001, 3'b011, 3'b111, 3'b011, 3'b001, 3'b000};
    fill_code = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
    clr_cnt();
    for (int i = 0; i < 6; i++) begin
      set_in(fill_pat[i]);
      step(10);
      chk("fill_nv", {nv1, nv0}, fill_code[i]);
    end
    chk("fill_upd_cnt", 3'(obs_upd_cnt), 3'd6);
    chk("fill_err_cnt", 2'(obs_err_cnt), 2'd0);

    // Asynchronous reset mid-cycle from a full tank, then re-debounce.
    set_in(3'b111);
    step(12);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_nv",   {nv1, nv0}, 2'b00);
    chk("arst_upd",  {1'b0, nv_upd}, 2'b00);
    chk("arst_erro", {1'b0, erro}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i < 7) chk("rfull_pre_nv", {nv1, nv0}, 2'b00);
      if (i == 7) begin
        chk("rfull_nv",  {nv1, nv0}, 2'b11);
        chk("rfull_upd", {1'b0, nv_upd}, 2'b01);
      end
    end

    // Randomized patterns with random hold times.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 3) != 0) begin
        wet = int'($urandom_range(0, 3));
        pat = 3'((1 << wet) - 1);
      end else begin
        pat = 3'($urandom_range(0, 7));
      end
      hold = int'($urandom_range(1, 9));
      set_in(pat);
      step(hold);
    end
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
